// File: rtl/fifo_burst_writer_if.sv
// Write-port bundle between the burst writer and the dual-clock byte FIFO.
// The master drives request/data and the slave returns the registered full flag.
interface fifo_burst_writer_if;
   logic       wrreq;
   logic [7:0] data;
   logic       wrfull;

   modport master (
      output wrreq,
      output data,
      input  wrfull
   );

   modport slave (
      input  wrreq,
      input  data,
      output wrfull
   );
endinterface

// File: rtl/fifo_burst_writer.sv
// Pushes a BURST_LEN-byte incrementing pattern into the FIFO on each trigger rising edge,
// honouring full back-pressure and counting triggers that land while a burst is running.
module fifo_burst_writer #(
   parameter int unsigned BURST_LEN    = 16,
   parameter logic [7:0]  START_VALUE  = 8'h00,
   parameter bit          SYNC_TRIGGER = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trigger,
   fifo_burst_writer_if.master        fifo,
   output logic                       busy,
   output logic                       done,
   output logic [7:0]                 drop_count
);

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   localparam logic [7:0] LastIdx   = 8'(BURST_LEN - 1);
   // Edges that must elapse after reset before the edge detector compares two real samples.
   localparam logic [1:0] ArmCycles = SYNC_TRIGGER ? 2'd3 : 2'd1;

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] drop_q, drop_d;
   logic       done_q, done_d;
   logic [1:0] arm_q, arm_d;
   logic       trig_prev_q;
   logic       trig_src;
   logic       arm_ok;
   logic       rise;
   logic       wrreq;

   if (SYNC_TRIGGER) begin : g_sync
      logic [1:0] sync_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[0], trigger};
         end
      end

      assign trig_src = sync_q[1];
   end else begin : g_direct
      assign trig_src = trigger;
   end

   assign arm_ok = (arm_q == ArmCycles);
   assign rise   = trig_src & ~trig_prev_q & arm_ok;
   assign wrreq  = (state_q == StWrite) & ~fifo.wrfull;

   always_comb begin
      arm_d = arm_q;
      if (!arm_ok) begin
         arm_d = arm_q + 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      drop_d  = drop_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rise) begin
               state_d = StWrite;
               cnt_d   = '0;
            end
         end
         StWrite: begin
            // Triggers during a burst are not queued, only counted.
            if (rise && (drop_q != 8'hFF)) begin
               drop_d = drop_q + 8'd1;
            end
            if (wrreq) begin
               data_d = data_q + 8'd1;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == LastIdx) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         data_q      <= START_VALUE;
         cnt_q       <= '0;
         drop_q      <= '0;
         done_q      <= 1'b0;
         arm_q       <= '0;
         trig_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         drop_q      <= drop_d;
         done_q      <= done_d;
         arm_q       <= arm_d;
         trig_prev_q <= trig_src;
      end
   end

   assign fifo.wrreq = wrreq;
   assign fifo.data  = data_q;
   assign busy       = (state_q == StWrite);
   assign done       = done_q;
   assign drop_count = drop_q;

   a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
      !(fifo.wrreq && fifo.wrfull));
   a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
      !(done && busy));

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: directed scenarios plus random trigger/full/reset traffic,
// all checked each cycle against a byte-stream model of the writer.
module tb_fifo_burst_writer;

   logic       clk;
   logic       rst_s  [2];
   logic       trig   [2];
   logic       full   [2];
   logic       wr_o   [2];
   logic [7:0] data_o [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic [7:0] drop_o [2];

   int n_checks;
   int n_fail;
   int cyc;
   bit chk_on;

   int wr_cnt   [2];
   int done_cnt [2];
   int busy_cyc [2];
   logic [7:0] wlog0 [$];
   int wedge0 [$];
   int done_cyc0;

   // Reference model state
   bit         m_busy [2];
   int         m_left [2];
   logic [7:0] m_data [2];
   bit         m_done [2];
   int         m_drop [2];
   logic [2:0] m_hist [2];
   int         m_n    [2];

   fifo_burst_writer_if if0 ();
   fifo_burst_writer_if if1 ();

   assign if0.wrfull = full[0];
   assign if1.wrfull = full[1];
   assign wr_o[0]    = if0.wrreq;
   assign wr_o[1]    = if1.wrreq;
   assign data_o[0]  = if0.data;
   assign data_o[1]  = if1.data;

   fifo_burst_writer #(
      .BURST_LEN    (16),
      .START_VALUE  (8'h00),
      .SYNC_TRIGGER (1'b1)
   ) u_dut0 (
      .clk        (clk),
      .rst        (rst_s[0]),
      .trigger    (trig[0]),
      .fifo       (if0),
      .busy       (busy_o[0]),
      .done       (done_o[0]),
      .drop_count (drop_o[0])
   );

   fifo_burst_writer #(
      .BURST_LEN    (1),
      .START_VALUE  (8'h00),
      .SYNC_TRIGGER (1'b0)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst_s[1]),
      .trigger    (trig[1]),
      .fifo       (if1),
      .busy       (busy_o[1]),
      .done       (done_o[1]),
      .drop_count (drop_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int burst_len(input int k);
      return (k == 0) ? 16 : 1;
   endfunction

   function automatic bit is_sync(input int k);
      return (k == 0);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock edge of the model: trigger edges seen through the sampling delay start a
   // burst of burst_len bytes, bytes go out while not full, edges during a burst are dropped.
   task automatic model_step(input int k, input bit r, input bit t, input bit f);
      bit src, prev, rise, was_busy;
      if (r) begin
         m_busy[k] = 1'b0;
         m_left[k] = 0;
         m_data[k] = 8'h00;
         m_done[k] = 1'b0;
         m_drop[k] = 0;
         m_hist[k] = '0;
         m_n[k]    = 0;
         return;
      end
      src      = is_sync(k) ? m_hist[k][1] : t;
      prev     = is_sync(k) ? m_hist[k][2] : m_hist[k][0];
      rise     = src && !prev && (m_n[k] >= (is_sync(k) ? 3 : 1));
      was_busy = m_busy[k];
      m_done[k] = 1'b0;
      if (was_busy && !f) begin
         m_data[k] = m_data[k] + 8'd1;
         m_left[k] = m_left[k] - 1;
         if (m_left[k] == 0) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
         end
      end
      if (rise) begin
         if (was_busy) begin
            if (m_drop[k] < 255) m_drop[k] = m_drop[k] + 1;
         end else begin
            m_busy[k] = 1'b1;
            m_left[k] = burst_len(k);
         end
      end
      m_hist[k] = {m_hist[k][1:0], t};
      if (m_n[k] < 100) m_n[k] = m_n[k] + 1;
   endtask

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         model_step(k, rst_s[k], trig[k], full[k]);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            check_val($sformatf("wrreq[%0d]", k), 32'(wr_o[k]), 32'(m_busy[k] && !full[k]));
            if (m_busy[k] && !full[k]) begin
               check_val($sformatf("data[%0d]", k), 32'(data_o[k]), 32'(m_data[k]));
            end
            check_val($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_busy[k]));
            check_val($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_done[k]));
            check_val($sformatf("drop[%0d]", k), 32'(drop_o[k]), 32'(m_drop[k]));
            if (wr_o[k] === 1'b1) begin
               wr_cnt[k]++;
               if (k == 0) begin
                  wlog0.push_back(data_o[0]);
                  wedge0.push_back(cyc + 1);
               end
            end
            if (done_o[k] === 1'b1) begin
               done_cnt[k]++;
               if (k == 0) done_cyc0 = cyc;
            end
            if (busy_o[k] === 1'b1) busy_cyc[k]++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_done(input int k, input int d0, input int limit, input string tag);
      int i = 0;
      while ((done_cnt[k] == d0) && (i < limit)) begin
         tick(1);
         i++;
      end
      check_val(tag, 32'(done_cnt[k] - d0), 32'd1);
   endtask

   task automatic wait_writes(input int k, input int target, input int limit, input string tag);
      int i = 0;
      while ((wr_cnt[k] < target) && (i < limit)) begin
         tick(1);
         i++;
      end
      check_val(tag, 32'(wr_cnt[k] >= target), 32'd1);
   endtask

   task automatic wait_busy(input int k, input int limit, input string tag);
      int i = 0;
      while ((busy_o[k] !== 1'b1) && (i < limit)) begin
         tick(1);
         i++;
      end
      check_val(tag, 32'(busy_o[k]), 32'd1);
   endtask

   task automatic fire0();
      trig[0] = 1'b1;
      tick(3);
      trig[0] = 1'b0;
   endtask

   task automatic pulse0();
      trig[0] = 1'b1;
      tick(2);
      trig[0] = 1'b0;
      tick(2);
   endtask

   initial begin
      int base, d0, bc, n_edge;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      chk_on   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         trig[k]     = 1'b0;
         full[k]     = 1'b0;
         rst_s[k]    = 1'b1;
         wr_cnt[k]   = 0;
         done_cnt[k] = 0;
         busy_cyc[k] = 0;
      end
      tick(3);
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      chk_on   = 1'b1;
      check_val("reset wrreq", 32'(wr_o[0]), 32'd0);
      check_val("reset data", 32'(data_o[0]), 32'h00);
      check_val("reset drop", 32'(drop_o[0]), 32'd0);
      tick(6);

      // First burst: latency, 00..0F, single done right after the 16th write
      base   = wr_cnt[0];
      d0     = done_cnt[0];
      trig[0] = 1'b1;
      n_edge = cyc + 1;
      tick(5);
      trig[0] = 1'b0;
      wait_done(0, d0, 60, "b1 done seen");
      tick(3);
      check_val("b1 writes", 32'(wr_cnt[0] - base), 32'd16);
      check_val("b1 first byte", 32'(wlog0[base]), 32'h00);
      check_val("b1 last byte", 32'(wlog0[base + 15]), 32'h0F);
      check_val("b1 latency", 32'(wedge0[base] - n_edge), 32'd3);
      check_val("b1 contiguous", 32'(wedge0[base + 15] - wedge0[base]), 32'd15);
      check_val("b1 done edge", 32'(done_cyc0), 32'(wedge0[base + 15]));
      check_val("b1 done count", 32'(done_cnt[0] - d0), 32'd1);
      check_val("b1 drops", 32'(drop_o[0]), 32'd0);

      // Sixteen more bursts: continuity and the FF -> 00 wrap
      for (int b = 0; b < 16; b++) begin
         d0 = done_cnt[0];
         fire0();
         wait_done(0, d0, 60, "burst done seen");
         tick(2);
         if (b == 0) begin
            check_val("b2 first byte", 32'(wlog0[16]), 32'h10);
            check_val("b2 last byte", 32'(wlog0[31]), 32'h1F);
         end
      end
      check_val("wrap total writes", 32'(wr_cnt[0]), 32'd272);
      check_val("wrap byte 255", 32'(wlog0[255]), 32'hFF);
      check_val("wrap byte 256", 32'(wlog0[256]), 32'h00);

      // Reset after the 8th byte of a burst
      base = wr_cnt[0];
      fire0();
      wait_writes(0, base + 8, 60, "rst 8 bytes seen");
      rst_s[0] = 1'b1;
      tick(1);
      rst_s[0] = 1'b0;
      check_val("rst wrreq", 32'(wr_o[0]), 32'd0);
      check_val("rst busy", 32'(busy_o[0]), 32'd0);
      check_val("rst data", 32'(data_o[0]), 32'h00);
      check_val("rst done", 32'(done_o[0]), 32'd0);
      d0 = done_cnt[0];
      tick(10);
      check_val("rst no done", 32'(done_cnt[0] - d0), 32'd0);

      // Back-pressure: full for 7 cycles from the 5th byte of a fresh burst
      base = wr_cnt[0];
      bc   = busy_cyc[0];
      d0   = done_cnt[0];
      fire0();
      wait_writes(0, base + 4, 60, "bp 4 bytes seen");
      full[0] = 1'b1;
      tick(1);
      check_val("bp hold wrreq", 32'(wr_o[0]), 32'd0);
      check_val("bp hold data", 32'(data_o[0]), 32'h04);
      tick(6);
      check_val("bp hold data end", 32'(data_o[0]), 32'h04);
      full[0] = 1'b0;
      wait_done(0, d0, 60, "bp done seen");
      tick(2);
      check_val("bp writes", 32'(wr_cnt[0] - base), 32'd16);
      check_val("bp first byte", 32'(wlog0[base]), 32'h00);
      check_val("bp 5th byte", 32'(wlog0[base + 4]), 32'h04);
      check_val("bp last byte", 32'(wlog0[base + 15]), 32'h0F);
      check_val("bp busy cycles", 32'(busy_cyc[0] - bc), 32'd23);

      // Three trigger edges during one burst
      base = wr_cnt[0];
      d0   = done_cnt[0];
      trig[0] = 1'b1;
      tick(2);
      trig[0] = 1'b0;
      wait_busy(0, 20, "drop burst busy");
      for (int p = 0; p < 3; p++) pulse0();
      wait_done(0, d0, 60, "drop done seen");
      tick(30);
      check_val("drop count 3", 32'(drop_o[0]), 32'd3);
      check_val("drop writes", 32'(wr_cnt[0] - base), 32'd16);
      check_val("drop one burst", 32'(done_cnt[0] - d0), 32'd1);

      // Saturation: 300 edges while a stalled burst holds busy
      base = wr_cnt[0];
      d0   = done_cnt[0];
      fire0();
      wait_busy(0, 20, "sat burst busy");
      full[0] = 1'b1;
      tick(2);
      for (int p = 0; p < 300; p++) pulse0();
      tick(4);
      check_val("drop saturate", 32'(drop_o[0]), 32'd255);
      full[0] = 1'b0;
      wait_done(0, d0, 60, "sat done seen");
      tick(2);
      check_val("sat writes", 32'(wr_cnt[0] - base), 32'd16);

      // Direct trigger, one-byte bursts, level held high
      base = wr_cnt[1];
      d0   = done_cnt[1];
      trig[1] = 1'b1;
      tick(20);
      trig[1] = 1'b0;
      tick(5);
      check_val("u1 writes", 32'(wr_cnt[1] - base), 32'd1);
      check_val("u1 done", 32'(done_cnt[1] - d0), 32'd1);
      check_val("u1 drops", 32'(drop_o[1]), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(7) == 0) trig[k] = ~trig[k];
            full[k]  = ($urandom_range(3) == 0);
            rst_s[k] = ($urandom_range(599) == 0);
         end
      end
      for (int k = 0; k < 2; k++) begin
         trig[k]  = 1'b0;
         full[k]  = 1'b0;
         rst_s[k] = 1'b0;
      end
      tick(40);
      check_val("final idle u0", 32'(busy_o[0]), 32'd0);
      check_val("final idle u1", 32'(busy_o[1]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
